// File: rtl/wb_stage_ctrl_pkg.sv
// Shared types and constants for the write-back stage controller:
// FSM state encoding and load/store access-size codes.
package wb_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  localparam logic [3:0] LS_BYTE = 4'b0001;
  localparam logic [3:0] LS_HALF = 4'b0011;
  localparam logic [3:0] LS_WORD = 4'b1111;

endpackage

// File: rtl/wb_stage_ctrl_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by addr
// out of the 32-bit response and sign- or zero-extends it.
module load_align
  import wb_stage_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  lsV,
  input  logic        loadX,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_sel  = rdata[{addr, 3'b000} +: 8];
    half_sel  = rdata[{addr[1], 4'b0000} +: 16];
    byte_sign = byte_sel[7] & ~loadX;
    half_sign = half_sel[15] & ~loadX;
    case (lsV)
      LS_BYTE: data = {{24{byte_sign}}, byte_sel};
      LS_HALF: data = {{16{half_sign}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// Write-back stage controller: waits for/buffers/discards data responses and
// drives the register-file write port. Define WB_DEBUG_TRACE_EN for trace ports.
module wb_stage_ctrl
  import wb_stage_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_stall,
  input  logic        wb_flush,
  input  logic        wb_hit_when_refill,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_res,
  input  logic        wb_load,
  input  logic        wb_loadX,
  input  logic [3:0]  wb_lsV,
  input  logic [1:0]  wb_data_addr,
  input  logic        wb_regwen,
  input  logic [4:0]  wb_wreg,
  input  logic        wb_data_req,
  input  logic        wb_cp0ren,
  input  logic [31:0] wb_cp0rdata,
  input  logic [1:0]  wb_hiloren,
  input  logic [31:0] wb_hilordata,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  wb_state_e   state_q, state_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;

  logic        data_avail;
  logic        stall_int;
  logic        retire;
  logic        flush_pending;
  logic [31:0] load_raw;
  logic [31:0] load_data;
  logic [31:0] wdata_int;
  logic        wen_int;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= RUN;
      buf_data_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign data_avail    = (state_q == HOLD) | (data_ok & (state_q != DRAIN));
  assign stall_int     = wb_data_req & ~data_avail & ~wb_flush;
  assign retire        = ~pipe_stall & ~stall_int & ~wb_flush;
  assign flush_pending = wb_flush & wb_data_req;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (flush_pending & ~data_ok) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (data_ok & wb_data_req & pipe_stall & ~wb_flush) begin
          buf_data_d = data_rdata;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (retire | wb_flush) state_d = RUN;
      end
      DRAIN: begin
        // A pulse retires one stale request; a new flushed request adds one.
        if (data_ok) begin
          if (!flush_pending) begin
            if (drain_cnt_q == 2'd0) state_d = RUN;
            else                     drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end else if (flush_pending && drain_cnt_q != 2'd3) begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign load_raw = (state_q == HOLD) ? buf_data_q : data_rdata;

  load_align u_load_align (
    .rdata (load_raw),
    .addr  (wb_data_addr),
    .lsV   (wb_lsV),
    .loadX (wb_loadX),
    .data  (load_data)
  );

  always_comb begin
    if (wb_load)          wdata_int = load_data;
    else if (wb_cp0ren)   wdata_int = wb_cp0rdata;
    else if (|wb_hiloren) wdata_int = wb_hilordata;
    else                  wdata_int = wb_res;
  end

  assign wen_int = retire & wb_regwen & ~wb_hit_when_refill & (wb_wreg != 5'd0);

  assign wb_stall = ~reset & stall_int;
  assign rf_wen   = ~reset & wen_int;
  assign rf_waddr = reset ? 5'd0 : wb_wreg;
  assign rf_wdata = reset ? 32'd0 : wdata_int;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^wb_pc;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: expected register writes are queued
// when an instruction is presented and popped when rf_wen fires.
module tb_wb_stage_ctrl;
  import wb_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_stall, wb_flush, wb_hit_when_refill;
  logic [31:0] wb_pc, wb_res;
  logic        wb_load, wb_loadX;
  logic [3:0]  wb_lsV;
  logic [1:0]  wb_data_addr;
  logic        wb_regwen;
  logic [4:0]  wb_wreg;
  logic        wb_data_req, wb_cp0ren;
  logic [31:0] wb_cp0rdata;
  logic [1:0]  wb_hiloren;
  logic [31:0] wb_hilordata;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        wb_stall, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];

  wb_stage_ctrl dut (
    .clk(clk), .reset(reset), .pipe_stall(pipe_stall), .wb_flush(wb_flush),
    .wb_hit_when_refill(wb_hit_when_refill), .wb_pc(wb_pc), .wb_res(wb_res),
    .wb_load(wb_load), .wb_loadX(wb_loadX), .wb_lsV(wb_lsV),
    .wb_data_addr(wb_data_addr), .wb_regwen(wb_regwen), .wb_wreg(wb_wreg),
    .wb_data_req(wb_data_req), .wb_cp0ren(wb_cp0ren), .wb_cp0rdata(wb_cp0rdata),
    .wb_hiloren(wb_hiloren), .wb_hilordata(wb_hilordata), .data_ok(data_ok),
    .data_rdata(data_rdata), .wb_stall(wb_stall), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every write must match the oldest expected write.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0 && rf_wen === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=%h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        if (rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
          miscompares++;
          $display("FAIL rf_write: got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                   rf_waddr, rf_wdata, e.waddr, e.wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_stall = 0; wb_flush = 0; wb_hit_when_refill = 0;
    wb_pc = 32'hBFC0_0000; wb_res = 32'h5A5A_A5A5;
    wb_load = 0; wb_loadX = 0; wb_lsV = LS_WORD; wb_data_addr = 0;
    wb_regwen = 0; wb_wreg = 0; wb_data_req = 0; wb_cp0ren = 0;
    wb_cp0rdata = 32'h0; wb_hiloren = 0; wb_hilordata = 32'h0;
    data_ok = 0; data_rdata = 32'h0;
  endtask

  task automatic load(input logic [3:0] lsv, input logic [1:0] addr,
                      input logic x, input logic [4:0] wreg);
    idle();
    wb_load = 1; wb_loadX = x; wb_lsV = lsv; wb_data_addr = addr;
    wb_regwen = 1; wb_wreg = wreg; wb_data_req = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    load(LS_WORD, 0, 0, 5'd5);
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", wb_stall); end
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b expected 0", rf_wen); end
    vectors++; if (rf_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
    vectors++; if (rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
    tick();
    reset = 0;
    idle();
    @(negedge clk);
    vectors++; if (dut.state_q !== RUN) begin miscompares++; $display("FAIL reset_state: got %0d expected RUN", dut.state_q); end
  endtask

  task automatic test_load_extend();
    logic [3:0]  t_lsv  [9] = '{LS_BYTE, LS_BYTE, LS_BYTE, LS_BYTE, LS_BYTE, LS_HALF, LS_HALF, LS_HALF, LS_WORD};
    logic [1:0]  t_addr [9] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
    logic        t_x    [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_exp  [9] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0001, 32'hFFFF_FF80,
                                32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_80FF,
                                32'h80FF_7F01};
    for (int i = 0; i < 9; i++) begin
      tick();
      load(t_lsv[i], t_addr[i], t_x[i], 5'(i + 1));
      data_ok = 1; data_rdata = 32'h80FF_7F01;
      sb.push_back('{5'(i + 1), t_exp[i]});
      @(negedge clk);
      vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL ext_stall[%0d]: got %b expected 0", i, wb_stall); end
      vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL ext_wen[%0d]: got %b expected 1", i, rf_wen); end
    end
  endtask

  task automatic test_late_response();
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) load(LS_WORD, 0, 0, 5'd7);
      @(negedge clk);
      vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL late_stall[%0d]: got %b expected 1", c, wb_stall); end
      vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL late_wen[%0d]: got %b expected 0", c, rf_wen); end
    end
    tick();
    data_ok = 1; data_rdata = 32'hCAFE_BABE;
    sb.push_back('{5'd7, 32'hCAFE_BABE});
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL late_release: got %b expected 0", wb_stall); end
    tick();
    idle();
  endtask

  task automatic test_hold();
    tick();
    load(LS_WORD, 0, 0, 5'd9);
    pipe_stall = 1; data_ok = 1; data_rdata = 32'h1234_5678;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL hold_wen0: got %b expected 0", rf_wen); end
    tick();
    data_ok = 0; data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++; if (dut.state_q !== HOLD) begin miscompares++; $display("FAIL hold_state: got %0d expected HOLD", dut.state_q); end
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL hold_wen1: got %b expected 0", rf_wen); end
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL hold_stall: got %b expected 0", wb_stall); end
    tick();
    pipe_stall = 0;
    sb.push_back('{5'd9, 32'h1234_5678});
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL hold_release: got %b expected 1", rf_wen); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (dut.state_q !== RUN) begin miscompares++; $display("FAIL hold_exit: got %0d expected RUN", dut.state_q); end
  endtask

  task automatic test_flush_drain();
    tick();
    load(LS_WORD, 0, 0, 5'd10);
    wb_flush = 1;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL flush_wen: got %b expected 0", rf_wen); end
    tick();
    load(LS_WORD, 0, 0, 5'd11);
    data_ok = 1; data_rdata = 32'hAAAA_0000;
    @(negedge clk);
    vectors++; if (dut.state_q !== DRAIN) begin miscompares++; $display("FAIL drain_state: got %0d expected DRAIN", dut.state_q); end
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL drain_stall: got %b expected 1", wb_stall); end
    tick();
    data_rdata = 32'hBBBB_0000;
    sb.push_back('{5'd11, 32'hBBBB_0000});
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL drain_own: got %b expected 1", rf_wen); end
    // Two stacked flushes: two stale pulses must be discarded.
    tick();
    load(LS_WORD, 0, 0, 5'd12); wb_flush = 1;
    tick();
    load(LS_WORD, 0, 0, 5'd13); wb_flush = 1;
    tick();
    load(LS_WORD, 0, 0, 5'd14);
    data_ok = 1; data_rdata = 32'h1111_0000;
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL drain2_stall0: got %b expected 1", wb_stall); end
    tick();
    data_rdata = 32'h2222_0000;
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL drain2_stall1: got %b expected 1", wb_stall); end
    tick();
    data_rdata = 32'h3333_0000;
    sb.push_back('{5'd14, 32'h3333_0000});
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL drain2_own: got %b expected 1", rf_wen); end
    // Flush coincident with the response: consumed, no write, stays RUN.
    tick();
    load(LS_WORD, 0, 0, 5'd15);
    wb_flush = 1; pipe_stall = 1; data_ok = 1; data_rdata = 32'h5555_5555;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL flush_ok_wen: got %b expected 0", rf_wen); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (dut.state_q !== RUN) begin miscompares++; $display("FAIL flush_ok_state: got %0d expected RUN", dut.state_q); end
  endtask

  task automatic test_wb_select();
    tick();
    idle(); wb_regwen = 1; wb_wreg = 0;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL r0_wen: got %b expected 0", rf_wen); end
    tick();
    idle(); wb_regwen = 1; wb_wreg = 5'd3; wb_hit_when_refill = 1;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL refill_wen: got %b expected 0", rf_wen); end
    tick();
    idle(); wb_regwen = 1; wb_wreg = 5'd4; wb_cp0ren = 1; wb_cp0rdata = 32'h0000_ABCD;
    wb_hiloren = 2'b01; wb_hilordata = 32'h9999_9999;
    sb.push_back('{5'd4, 32'h0000_ABCD});
    tick();
    idle(); wb_regwen = 1; wb_wreg = 5'd20; wb_hiloren = 2'b10; wb_hilordata = 32'h0BAD_F00D;
    sb.push_back('{5'd20, 32'h0BAD_F00D});
    tick();
    idle(); wb_regwen = 1; wb_wreg = 5'd31; wb_res = 32'h8000_0004; pipe_stall = 1;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL frozen_wen: got %b expected 0", rf_wen); end
    tick();
    pipe_stall = 0;
    sb.push_back('{5'd31, 32'h8000_0004});
    tick();
    idle(); wb_data_req = 1;
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL store_stall: got %b expected 1", wb_stall); end
    tick();
    data_ok = 1;
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL store_release: got %b expected 0", wb_stall); end
    tick();
    idle();
  endtask

  task automatic test_reset_in_hold();
    tick();
    load(LS_WORD, 0, 0, 5'd16);
    pipe_stall = 1; data_ok = 1; data_rdata = 32'h7777_7777;
    tick();
    data_ok = 0; reset = 1;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0 || wb_stall !== 1'b0 || rf_wdata !== 32'd0) begin
      miscompares++; $display("FAIL hold_reset_out: got wen=%b stall=%b wdata=%h expected 0/0/0", rf_wen, wb_stall, rf_wdata);
    end
    tick();
    reset = 0;
    idle();
    @(negedge clk);
    vectors++; if (dut.state_q !== RUN) begin miscompares++; $display("FAIL hold_reset_state: got %0d expected RUN", dut.state_q); end
    vectors++; if (rf_wen !== 1'b0 || wb_stall !== 1'b0) begin
      miscompares++; $display("FAIL hold_reset_idle: got wen=%b stall=%b expected 0/0", rf_wen, wb_stall);
    end
    tick();
    load(LS_WORD, 0, 0, 5'd17);
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL hold_reset_nobuf: got %b expected 1", wb_stall); end
    tick();
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (2) tick();
    test_reset();
    test_load_extend();
    test_late_response();
    test_hold();
    test_flush_drain();
    test_wb_select();
    test_reset_in_hold();
    tick();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
